// File: rtl/l2_req_out_packetizer.sv
// Serialises one L2 coherence request into head/addr[/data] NoC flits; flits start 1 cycle after capture.
// Holds output flit stable under backpressure; accepts a new request only when idle or on the tail handshake.
module l2_req_out_packetizer #(
  parameter int          COH_MSG_W      = 5,
  parameter int          LINE_ADDR_W    = 28,
  parameter int          WORDS_PER_LINE = 4,
  parameter int          LINE_W         = 128,
  parameter int          FLIT_W         = 64,
  parameter logic [31:0] DATA_MSG_MASK  = 32'h0000_00C8,
  parameter int          DEST_LSB       = 0,
  parameter int          DEST_BITS      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [5:0]                my_tile_id,
  input  logic [5:0]                llc_base_id,
  input  logic                      l2_req_out_valid,
  output logic                      l2_req_out_ready,
  input  logic [COH_MSG_W-1:0]      l2_req_out_coh_msg,
  input  logic                      l2_req_out_hprot,
  input  logic [LINE_ADDR_W-1:0]    l2_req_out_addr,
  input  logic [WORDS_PER_LINE-1:0] l2_req_out_word_mask,
  input  logic [LINE_W-1:0]         l2_req_out_line,
  output logic                      noc_out_valid,
  input  logic                      noc_out_ready,
  output logic [FLIT_W-1:0]         noc_out_data,
  output logic                      busy
);

  localparam int PAY_W    = FLIT_W - 2;
  localparam int CHUNKS   = (LINE_W + PAY_W - 1) / PAY_W;
  localparam int PADDED_W = CHUNKS * PAY_W;
  localparam int CNT_W    = $clog2(CHUNKS) + 1;
  localparam int HDR_W    = 12 + COH_MSG_W + 1 + WORDS_PER_LINE;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_ADDR, S_DATA} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [COH_MSG_W-1:0]      coh_q;
  logic                      hprot_q;
  logic [LINE_ADDR_W-1:0]    addr_q;
  logic [WORDS_PER_LINE-1:0] wm_q;
  logic [LINE_W-1:0]         line_q;
  logic                      has_data_q;

  logic                      fire;
  logic                      accept;
  logic                      last_flit;
  logic [1:0]                preamble;
  logic [PAY_W-1:0]          payload;
  logic [5:0]                home_off;
  logic [5:0]                dest;
  logic [HDR_W-1:0]          head_fields;
  logic [PADDED_W-1:0]       line_pad;

  if (DEST_BITS == 0) begin : g_no_home_sel
    assign home_off = '0;
  end else begin : g_home_sel
    assign home_off = 6'(addr_q[DEST_LSB +: DEST_BITS]);
  end

  // 6-bit add wraps modulo 64 across the tile id space
  assign dest        = llc_base_id + home_off;
  assign head_fields = {dest, my_tile_id, coh_q, hprot_q, wm_q};
  assign line_pad    = PADDED_W'(line_q);
  assign fire        = noc_out_valid & noc_out_ready;
  assign accept      = l2_req_out_valid & l2_req_out_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_flit     = 1'b0;
    preamble      = 2'b00;
    payload       = '0;
    noc_out_valid = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (l2_req_out_valid) state_d = S_HEAD;
      end
      S_HEAD: begin
        preamble = 2'b10;
        payload  = {head_fields, {(PAY_W - HDR_W){1'b0}}};
        if (fire) state_d = S_ADDR;
      end
      S_ADDR: begin
        last_flit = !has_data_q;
        preamble  = has_data_q ? 2'b00 : 2'b01;
        payload   = PAY_W'(addr_q);
        if (fire) begin
          if (has_data_q) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end else begin
            state_d = l2_req_out_valid ? S_HEAD : S_IDLE;
          end
        end
      end
      S_DATA: begin
        last_flit = (cnt_q == LAST_CHUNK);
        preamble  = last_flit ? 2'b01 : 2'b00;
        payload   = line_pad[int'(cnt_q) * PAY_W +: PAY_W];
        if (fire) begin
          if (last_flit) state_d = l2_req_out_valid ? S_HEAD : S_IDLE;
          else           cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Ready on the tail handshake lets the next head follow without a bubble
    l2_req_out_ready = (state_q == S_IDLE) | (fire & last_flit);
    noc_out_data     = {preamble, payload};
    busy             = (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      coh_q      <= '0;
      hprot_q    <= 1'b0;
      addr_q     <= '0;
      wm_q       <= '0;
      line_q     <= '0;
      has_data_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        coh_q      <= l2_req_out_coh_msg;
        hprot_q    <= l2_req_out_hprot;
        addr_q     <= l2_req_out_addr;
        wm_q       <= l2_req_out_word_mask;
        line_q     <= l2_req_out_line;
        has_data_q <= DATA_MSG_MASK[l2_req_out_coh_msg];
      end
    end
  end

endmodule

// File: tb/tb_l2_req_out_packetizer.sv
// Directed plus random requests against a flit-queue reference model; every cycle checks
// valid/busy/ready/flit against the queue of flits the accepted requests must produce.
module tb_l2_req_out_packetizer;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   my_tile_id;
  logic [5:0]   llc_base_id;
  logic         l2_req_out_valid;
  logic         l2_req_out_ready;
  logic [4:0]   req_coh;
  logic         req_hprot;
  logic [27:0]  req_addr;
  logic [3:0]   req_wm;
  logic [127:0] req_line;
  logic         noc_out_valid;
  logic         noc_out_ready;
  logic [63:0]  noc_out_data;
  logic         busy;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          accepted;
  logic [63:0] q[$];
  int          fire_cyc[$];

  always #5 clk = ~clk;

  l2_req_out_packetizer dut (
    .clk                  (clk),
    .rst                  (rst),
    .my_tile_id           (my_tile_id),
    .llc_base_id          (llc_base_id),
    .l2_req_out_valid     (l2_req_out_valid),
    .l2_req_out_ready     (l2_req_out_ready),
    .l2_req_out_coh_msg   (req_coh),
    .l2_req_out_hprot     (req_hprot),
    .l2_req_out_addr      (req_addr),
    .l2_req_out_word_mask (req_wm),
    .l2_req_out_line      (req_line),
    .noc_out_valid        (noc_out_valid),
    .noc_out_ready        (noc_out_ready),
    .noc_out_data         (noc_out_data),
    .busy                 (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flits a request must produce: head, address, then 62-bit line slices when the type carries data
  task automatic push_req();
    logic [31:0]  data_types;
    logic [127:0] sh;
    logic [5:0]   d;
    bit           hd;
    data_types = 32'h0000_00C8;
    hd = data_types[req_coh];
    d  = 6'((int'(llc_base_id) + int'(req_addr % 4)) % 64);
    q.push_back({2'b10, d, my_tile_id, req_coh, req_hprot, req_wm, 40'h0});
    q.push_back({hd ? 2'b00 : 2'b01, 34'h0, req_addr});
    if (hd) begin
      for (int i = 0; i < 3; i++) begin
        sh = req_line >> (i * 62);
        q.push_back({(i == 2) ? 2'b01 : 2'b00, sh[61:0]});
      end
    end
  endtask

  // Called at a falling edge with inputs set; checks, updates the model, advances one cycle
  task automatic step();
    bit ev;
    bit er;
    #1;
    ev = (q.size() != 0);
    er = (q.size() == 0) || (noc_out_ready && q.size() == 1);
    chk("valid", noc_out_valid, ev);
    chk("busy", busy, ev);
    chk("ready", l2_req_out_ready, er);
    if (ev) chk("flit", noc_out_data, q[0]);
    if (ev && noc_out_ready) begin
      void'(q.pop_front());
      fire_cyc.push_back(cyc);
    end
    accepted = l2_req_out_valid && er;
    if (accepted) push_req();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_req(input logic [4:0] c, input logic h, input logic [27:0] a,
                         input logic [3:0] w, input logic [127:0] l);
    req_coh = c; req_hprot = h; req_addr = a; req_wm = w; req_line = l;
  endtask

  task automatic send();
    l2_req_out_valid = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 40 && !accepted; k++) step();
    chk("accept_timeout", accepted, 1'b1);
    l2_req_out_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 80 && q.size() != 0; k++) step();
    chk("drain_timeout", q.size(), 0);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    l2_req_out_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    q.delete();
    #1;
    chk("rst_valid", noc_out_valid, 1'b0);
    chk("rst_data", noc_out_data, 64'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", l2_req_out_ready, 1'b1);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; l2_req_out_valid = 1'b0; noc_out_ready = 1'b1;
    my_tile_id = 6'd3; llc_base_id = 6'd8;
    set_req(5'd0, 1'b0, 28'h0, 4'h0, 128'h0);
    @(negedge clk);
    do_reset();

    // non-data request: head + tail
    set_req(5'd1, 1'b1, 28'h0ABCDE5, 4'hF, 128'h0);
    fire_cyc.delete();
    send();
    chk("t1_head_dest", noc_out_data[61:56], 6'd9);
    chk("t1_head_src", noc_out_data[55:50], 6'd3);
    drain();
    chk("t1_flits", fire_cyc.size(), 2);

    // data request: head, addr, 3 chunks
    set_req(5'd3, 1'b0, 28'h1234567, 4'h3, 128'h0123456789ABCDEF0123456789ABCDEF);
    fire_cyc.delete();
    send();
    chk("t2_head_pre", noc_out_data[63:62], 2'b10);
    drain();
    chk("t2_flits", fire_cyc.size(), 5);

    // backpressure mid-data
    set_req(5'd6, 1'b1, 28'hFEDCBA9, 4'h5, 128'hF00D_CAFE_1234_5678_9ABC_DEF0_5555_AAAA);
    fire_cyc.delete();
    send();
    step(); step(); step();
    noc_out_ready = 1'b0;
    repeat (4) step();
    noc_out_ready = 1'b1;
    drain();
    chk("t3_flits", fire_cyc.size(), 5);

    // back-to-back non-data requests
    fire_cyc.delete();
    set_req(5'd1, 1'b0, 28'h0000011, 4'h1, 128'h0);
    send();
    set_req(5'd2, 1'b1, 28'h0000022, 4'h2, 128'h0);
    send();
    drain();
    chk("t4_flits", fire_cyc.size(), 4);
    if (fire_cyc.size() == 4) chk("t4_no_bubble", fire_cyc[3] - fire_cyc[0], 3);

    // reset during a data flit, then a clean packet
    set_req(5'd7, 1'b0, 28'h0000003, 4'hF, {4{32'hDEAD_BEEF}});
    send();
    step(); step();
    do_reset();
    set_req(5'd1, 1'b0, 28'h0000001, 4'h8, 128'h0);
    send();
    chk("t5_clean_head", noc_out_data[63:62], 2'b10);
    drain();

    // home tile id wraps modulo 64
    llc_base_id = 6'd63;
    set_req(5'd1, 1'b0, 28'h0000002, 4'h1, 128'h0);
    send();
    chk("t6_wrap_dest", noc_out_data[61:56], 6'd1);
    drain();

    // random requests, random backpressure and gaps
    my_tile_id  = 6'($urandom_range(63));
    llc_base_id = 6'($urandom_range(63));
    for (int n = 0; n < 40; n++) begin
      set_req(5'($urandom_range(31)), 1'($urandom_range(1)), 28'($urandom()),
              4'($urandom_range(15)), {$urandom(), $urandom(), $urandom(), $urandom()});
      l2_req_out_valid = 1'b1;
      accepted = 1'b0;
      for (int k = 0; k < 200 && !accepted; k++) begin
        noc_out_ready = ($urandom_range(3) != 0);
        step();
      end
      chk("rand_accept", accepted, 1'b1);
      l2_req_out_valid = 1'b0;
      repeat ($urandom_range(2)) begin
        noc_out_ready = ($urandom_range(3) != 0);
        step();
      end
    end
    noc_out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
